// File: rtl/uparc_rf_writeback.sv
// Register-file writeback arbiter: ALU results go straight through, LSU/MDU results wait in a 2-deep in-order queue.
// Optional UPARC_WB_SCOREBOARD_EN: decode queued destinations onto pend_mask (otherwise pend_mask is tied to 0).
module uparc_rf_writeback #(
  parameter int STALL_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic [4:0]  rd,
  output logic [31:0] rd_data,
  output logic        alu_stall,
  output logic [31:0] pend_mask
);

  localparam logic [2:0] THRESH = 3'(STALL_THRESH);

  logic [1:0]  count;
  logic [2:0]  wait_cnt;
  logic [4:0]  q_rd   [2];
  logic [31:0] q_data [2];

  logic        lsu_acc;
  logic        mdu_acc;
  logic        enq;
  logic        deq;
  logic        alu_wr;
  logic [4:0]  enq_rd;
  logic [31:0] enq_data;
  logic [1:0]  occ;
  logic [1:0]  count_nxt;
  logic [2:0]  wait_nxt;

  always_comb begin
    lsu_ready = (count < 2'd2);
    mdu_ready = (count < 2'd2) && !lsu_valid;
    lsu_acc   = lsu_valid && lsu_ready;
    mdu_acc   = mdu_valid && mdu_ready;
    enq_rd    = lsu_acc ? lsu_rd   : mdu_rd;
    enq_data  = lsu_acc ? lsu_data : mdu_data;
    // Writes to x0 complete the handshake but never occupy a slot.
    enq       = (lsu_acc || mdu_acc) && (enq_rd != 5'd0);
    alu_wr    = alu_valid && (alu_rd != 5'd0);
    deq       = !alu_wr && (count != 2'd0);
    occ       = count - {1'b0, deq};
    count_nxt = occ + {1'b0, enq};
    if ((count == 2'd0) || deq) begin
      wait_nxt = 3'd0;
    end else if (wait_cnt != 3'd7) begin
      wait_nxt = wait_cnt + 3'd1;
    end else begin
      wait_nxt = wait_cnt;
    end
  end

  // Write-port stage: control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      wait_cnt  <= 3'd0;
      alu_stall <= 1'b0;
      rd        <= 5'd0;
      rd_data   <= 32'd0;
    end else begin
      count     <= count_nxt;
      wait_cnt  <= wait_nxt;
      alu_stall <= (wait_nxt >= THRESH);
      if (alu_wr) begin
        rd      <= alu_rd;
        rd_data <= alu_data;
      end else if (deq) begin
        rd      <= q_rd[0];
        rd_data <= q_data[0];
      end else begin
        rd      <= 5'd0;
        rd_data <= 32'd0;
      end
    end
  end

  // Queue storage: slot 0 is always the head; contents are meaningless beyond count
  always_ff @(posedge clk) begin
    if (deq) begin
      q_rd[0]   <= q_rd[1];
      q_data[0] <= q_data[1];
    end
    if (enq) begin
      if (occ == 2'd0) begin
        q_rd[0]   <= enq_rd;
        q_data[0] <= enq_data;
      end else begin
        q_rd[1]   <= enq_rd;
        q_data[1] <= enq_data;
      end
    end
  end

`ifdef UPARC_WB_SCOREBOARD_EN
  always_comb begin
    pend_mask = 32'd0;
    if (count != 2'd0) pend_mask[q_rd[0]] = 1'b1;
    if (count == 2'd2) pend_mask[q_rd[1]] = 1'b1;
    pend_mask[0] = 1'b0;
  end
`else
  assign pend_mask = 32'd0;
`endif

endmodule
